// File: rtl/spi_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// spi_fifo_ctrl
//   Buffered front-end for spi_master. Bytes from a valid/ready producer are
//   queued in a TX FIFO. One spi_master transaction is launched per byte. Each
//   received byte is queued in an RX FIFO that a valid/ready consumer drains.
//   A transaction that gets no spi_done within TIMEOUT_CYC cycles is abandoned,
//   and the sticky timeout_err flag is set.
//
// Parameters
//   FIFO_DEPTH   entries per FIFO (power of 2, >= 2)
//   TIMEOUT_CYC  clk cycles spent in WAIT before a transaction is abandoned
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   enable                     allows new transactions to be launched
//   s_tx_valid/ready/data      producer byte stream into the TX FIFO
//   m_rx_valid/ready/data      consumer byte stream out of the RX FIFO
//   tx_count, rx_count         FIFO occupancies
//   busy                       controller FSM is not idle
//   timeout_err, clr_err       sticky timeout flag and its clear
//   spi_start, spi_tx_data     launch request and byte to spi_master
//   spi_rx_data, spi_done      received byte and completion pulse from spi_master
// -----------------------------------------------------------------------------
module spi_fifo_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          s_tx_valid,
    output logic                          s_tx_ready,
    input  logic [7:0]                    s_tx_data,
    output logic                          m_rx_valid,
    input  logic                          m_rx_ready,
    output logic [7:0]                    m_rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          busy,
    output logic                          timeout_err,
    input  logic                          clr_err,
    output logic                          spi_start,
    output logic [7:0]                    spi_tx_data,
    input  logic [7:0]                    spi_rx_data,
    input  logic                          spi_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // ---------------------------------------------------------------- storage
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wptr;
    logic [AW-1:0] r_tx_rptr;
    logic [AW-1:0] r_rx_wptr;
    logic [AW-1:0] r_rx_rptr;
    logic [CW-1:0] r_tx_count;
    logic [CW-1:0] r_rx_count;

    // ---------------------------------------------------------------- FSM regs
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_spi_start;
    logic [7:0]    r_spi_tx_data;
    logic          r_timeout_err;

    // ---------------------------------------------------------------- strobes
    logic w_tx_push;
    logic w_tx_pop;
    logic w_rx_push;
    logic w_rx_pop;
    logic w_launch_ok;

    assign s_tx_ready = (r_tx_count != CW'(FIFO_DEPTH));
    assign m_rx_valid = (r_rx_count != '0);

    assign w_tx_push = s_tx_valid & s_tx_ready;
    // LAUNCH is only entered with a non-empty TX FIFO, and nothing else pops.
    assign w_tx_pop  = (r_state == ST_LAUNCH);
    // Only a completion seen while waiting is a real result; stray pulses drop.
    assign w_rx_push = (r_state == ST_WAIT) & spi_done;
    assign w_rx_pop  = m_rx_valid & m_rx_ready;

    // Requiring a free RX slot before launch reserves room for the reply, so
    // the RX push on spi_done can never overflow (one transaction in flight).
    assign w_launch_ok = enable & (r_tx_count != '0) & (r_rx_count != CW'(FIFO_DEPTH));

    // Head is forced to zero while empty so the output is defined after reset.
    assign m_rx_data   = m_rx_valid ? r_rx_mem[r_rx_rptr] : 8'h00;
    assign tx_count    = r_tx_count;
    assign rx_count    = r_rx_count;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;
    assign spi_start   = r_spi_start;
    assign spi_tx_data = r_spi_tx_data;

    // ---------------------------------------------------------------- RAM writes
    // Contents need no reset: occupancy counters decide what is valid.
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= s_tx_data;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= spi_rx_data;
        end
    end

    // ---------------------------------------------------------------- TX pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + CW'(1);
                2'b01:   r_tx_count <= r_tx_count - CW'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- RX pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + CW'(1);
                2'b01:   r_rx_count <= r_rx_count - CW'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_spi_start   <= 1'b0;
            r_spi_tx_data <= 8'h00;
            r_timeout_err <= 1'b0;
        end else begin
            r_spi_start <= 1'b0;
            // A timeout in the same cycle overrides this clear (later assignment).
            if (clr_err) begin
                r_timeout_err <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_launch_ok) begin
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    // Start pulse and data are registered together, and the
                    // data holds until the next launch.
                    r_spi_start   <= 1'b1;
                    r_spi_tx_data <= r_tx_mem[r_tx_rptr];
                    r_timer       <= '0;
                    r_state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (spi_done) begin
                        r_state <= ST_GAP;
                    end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_GAP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_GAP: begin
                    // Gives spi_master a cycle to return to idle.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
module tb_spi_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int TOUT  = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       s_tx_valid = 1'b0;
    logic       s_tx_ready;
    logic [7:0] s_tx_data = 8'h00;
    logic       m_rx_valid;
    logic       m_rx_ready = 1'b0;
    logic [7:0] m_rx_data;
    logic [3:0] tx_count;
    logic [3:0] rx_count;
    logic       busy;
    logic       timeout_err;
    logic       clr_err = 1'b0;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic [7:0] spi_rx_data = 8'h00;
    logic       spi_done = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    spi_fifo_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .s_tx_valid  (s_tx_valid),
        .s_tx_ready  (s_tx_ready),
        .s_tx_data   (s_tx_data),
        .m_rx_valid  (m_rx_valid),
        .m_rx_ready  (m_rx_ready),
        .m_rx_data   (m_rx_data),
        .tx_count    (tx_count),
        .rx_count    (rx_count),
        .busy        (busy),
        .timeout_err (timeout_err),
        .clr_err     (clr_err),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_rx_data (spi_rx_data),
        .spi_done    (spi_done)
    );

    // spi_master stand-in: answers each start 3 negedges later with ~tx byte.
    int         n_starts = 0;
    int         m_cnt = 0;
    logic [7:0] m_byte = 8'h00;
    bit         suppress = 1'b0;

    always @(negedge clk) begin
        spi_done = 1'b0;
        if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0 && !suppress) begin
                spi_done    = 1'b1;
                spi_rx_data = ~m_byte;
                $display("xfer: tx=0x%02h rx=0x%02h", m_byte, ~m_byte);
            end
        end
        if (spi_start) begin
            m_byte = spi_tx_data;
            m_cnt  = 3;
            n_starts++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        s_tx_valid = 1'b0;
        m_rx_ready = 1'b0;
        clr_err    = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Push one byte, waiting (bounded) for space.
    task automatic push(input logic [7:0] b);
        int w;
        w = 0;
        while (!s_tx_ready && w < 200) begin
            tick(1);
            w++;
        end
        check_val("push_ready", {31'd0, s_tx_ready}, 32'd1);
        s_tx_valid = 1'b1;
        s_tx_data  = b;
        tick(1);
        s_tx_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_val(tag, {24'd0, m_rx_data}, {24'd0, exp});
        m_rx_ready = 1'b1;
        tick(1);
        m_rx_ready = 1'b0;
    endtask

    initial begin
        int         base;
        int         w;
        logic [7:0] b;

        // ---------------- 1: reset values, single transfer, latency
        do_reset();
        check_val("rst_tx_ready", {31'd0, s_tx_ready}, 32'd1);
        check_val("rst_rx_valid", {31'd0, m_rx_valid}, 32'd0);
        check_val("rst_counts",   {24'd0, tx_count, rx_count}, 32'd0);
        check_val("rst_busy",     {31'd0, busy}, 32'd0);
        check_val("rst_err",      {31'd0, timeout_err}, 32'd0);
        check_val("rst_start",    {31'd0, spi_start}, 32'd0);
        check_val("rst_txd",      {24'd0, spi_tx_data}, 32'd0);
        check_val("rst_rxd",      {24'd0, m_rx_data}, 32'd0);
        enable = 1'b1;
        base   = n_starts;
        push(8'hAA);
        tick(1);
        check_val("t1_start_n1", {31'd0, spi_start}, 32'd0);
        tick(1);
        check_val("t1_start_n2", {31'd0, spi_start}, 32'd1);
        check_val("t1_txd",      {24'd0, spi_tx_data}, 32'hAA);
        tick(1);
        check_val("t1_start_n3", {31'd0, spi_start}, 32'd0);
        tick(20);
        check_val("t1_nstart", n_starts - base, 32'd1);
        check_val("t1_rxcnt",  {28'd0, rx_count}, 32'd1);
        check_val("t1_busy",   {31'd0, busy}, 32'd0);
        pop_check("t1_rxd", 8'h55);
        check_val("t1_rxcnt0", {28'd0, rx_count}, 32'd0);

        // ---------------- 2: fill with enable=0, reject 9th, then drain in order
        do_reset();
        base       = n_starts;
        s_tx_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_tx_data = 8'(i);
            tick(1);
        end
        check_val("t2_full_cnt",   {28'd0, tx_count}, 32'd8);
        check_val("t2_full_ready", {31'd0, s_tx_ready}, 32'd0);
        s_tx_data = 8'h09;
        tick(1);
        s_tx_valid = 1'b0;
        check_val("t2_reject_cnt", {28'd0, tx_count}, 32'd8);
        check_val("t2_no_start",   n_starts - base, 32'd0);
        enable = 1'b1;
        tick(80);
        check_val("t2_nstart", n_starts - base, 32'd8);
        check_val("t2_txcnt",  {28'd0, tx_count}, 32'd0);
        check_val("t2_rxcnt",  {28'd0, rx_count}, 32'd8);
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            pop_check("t2_order", ~b);
        end

        // ---------------- 3: RX backpressure holds the 9th byte
        do_reset();
        enable = 1'b1;
        base   = n_starts;
        for (int i = 0; i < 9; i++) begin
            push(8'h10 + 8'(i));
        end
        tick(80);
        check_val("t3_nstart8", n_starts - base, 32'd8);
        check_val("t3_rxcnt8",  {28'd0, rx_count}, 32'd8);
        check_val("t3_txcnt1",  {28'd0, tx_count}, 32'd1);
        check_val("t3_busy0",   {31'd0, busy}, 32'd0);
        pop_check("t3_first", 8'hEF);
        tick(20);
        check_val("t3_nstart9", n_starts - base, 32'd9);
        check_val("t3_txcnt0",  {28'd0, tx_count}, 32'd0);
        check_val("t3_rxcnt",   {28'd0, rx_count}, 32'd8);
        for (int i = 1; i <= 8; i++) begin
            b = 8'h10 + 8'(i);
            pop_check("t3_order", ~b);
        end

        // ---------------- 4: timeout, sticky flag, clear, clear-vs-timeout
        do_reset();
        enable   = 1'b1;
        suppress = 1'b1;
        push(8'h33);
        tick(TOUT + 1);
        check_val("t4_err_before", {31'd0, timeout_err}, 32'd0);
        check_val("t4_busy_wait",  {31'd0, busy}, 32'd1);
        tick(1);
        check_val("t4_err_set", {31'd0, timeout_err}, 32'd1);
        tick(5);
        check_val("t4_no_rxpush", {28'd0, rx_count}, 32'd0);
        suppress = 1'b0;
        push(8'h44);
        tick(20);
        check_val("t4_rxcnt",  {28'd0, rx_count}, 32'd1);
        check_val("t4_sticky", {31'd0, timeout_err}, 32'd1);
        pop_check("t4_rxd", 8'hBB);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check_val("t4_cleared", {31'd0, timeout_err}, 32'd0);
        suppress = 1'b1;
        push(8'h45);
        tick(TOUT + 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check_val("t4_tout_wins", {31'd0, timeout_err}, 32'd1);
        tick(5);
        suppress = 1'b0;

        // ---------------- 5: async reset during WAIT
        do_reset();
        enable = 1'b1;
        base   = n_starts;
        push(8'h66);
        tick(4);
        check_val("t5_in_wait", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("t5_busy",  {31'd0, busy}, 32'd0);
        check_val("t5_ready", {31'd0, s_tx_ready}, 32'd1);
        check_val("t5_cnts",  {24'd0, tx_count, rx_count}, 32'd0);
        check_val("t5_start", {31'd0, spi_start}, 32'd0);
        check_val("t5_txd",   {24'd0, spi_tx_data}, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(30);
        check_val("t5_nstart", n_starts - base, 32'd1);
        check_val("t5_rxcnt",  {28'd0, rx_count}, 32'd0);
        check_val("t5_idle",   {31'd0, busy}, 32'd0);

        // ---------------- 6: simultaneous push/pop on both FIFOs
        do_reset();
        base = n_starts;
        for (int i = 0; i < 3; i++) begin
            push(8'h70 + 8'(i));
        end
        check_val("t6_cnt3", {28'd0, tx_count}, 32'd3);
        enable = 1'b1;
        tick(1);
        check_val("t6_launch", {31'd0, busy}, 32'd1);
        s_tx_valid = 1'b1;
        s_tx_data  = 8'h73;
        tick(1);
        s_tx_valid = 1'b0;
        check_val("t6_txcnt_same", {28'd0, tx_count}, 32'd3);
        check_val("t6_start",      {31'd0, spi_start}, 32'd1);
        check_val("t6_txd",        {24'd0, spi_tx_data}, 32'h70);
        w = 0;
        while (rx_count != 4'd1 && w < 60) begin
            tick(1);
            w++;
        end
        check_val("t6_wait_rx1", {28'd0, rx_count}, 32'd1);
        w = 0;
        while (w < 60) begin
            @(negedge clk);
            #1;
            if (spi_done) break;
            w++;
        end
        check_val("t6_wait_done", {31'd0, spi_done}, 32'd1);
        m_rx_ready = 1'b1;
        tick(1);
        m_rx_ready = 1'b0;
        check_val("t6_rxcnt_same", {28'd0, rx_count}, 32'd1);
        check_val("t6_head",       {24'd0, m_rx_data}, 32'h8E);
        tick(40);
        check_val("t6_nstart", n_starts - base, 32'd4);
        check_val("t6_rxcnt3", {28'd0, rx_count}, 32'd3);
        pop_check("t6_ord1", 8'h8E);
        pop_check("t6_ord2", 8'h8D);
        pop_check("t6_ord3", 8'h8C);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
